// File: rtl/jtcontra_colmix.sv
// ============================================================================
// Module      : jtcontra_colmix
// Description : Two-chip priority colour mixer with CPU-writable 256x16 palette
//               and blanking delay. Optional palette clear on reset:
//               define JTCONTRA_PAL_CLEAR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jtcontra_colmix #(
    parameter int PRIO_A    = 1,
    parameter int BLANK_DLY = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [6:0] pxl_a,
    input  logic [6:0] pxl_b,
    input  logic [1:0] gfx_en,
    input  logic       cpu_cen,
    input  logic       cs,
    input  logic       cpu_rnw,
    input  logic [8:0] addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] dout,
    output logic       busy,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0]           r_pal_lo [256];
    logic [7:0]           r_pal_hi [256];
    logic [7:0]           r_vid_lo;
    logic [6:0]           r_vid_hi;
    logic [7:0]           r_dout;
    logic [7:0]           r_idx;
    logic [BLANK_DLY-1:0] r_hbl;
    logic [BLANK_DLY-1:0] r_vbl;
    logic [14:0]          r_rgb;

    logic       w_a_opq, w_b_opq, w_cpu_we, w_show;
    logic       w_we_lo, w_we_hi;
    logic [7:0] w_wa, w_wd, w_idx;
    logic [14:0] w_pal, w_col;

    assign w_cpu_we = cs & ~cpu_rnw & cpu_cen & ~busy;

`ifdef JTCONTRA_PAL_CLEAR_EN
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0] r_state, w_state_nxt;
    logic [8:0] r_clr_cnt;
    logic       w_clr_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= 9'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 9'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_CLEAR;
            S_CLEAR: if (&r_clr_cnt) w_state_nxt = S_DONE;
            default: w_state_nxt = S_DONE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_DONE);
        w_clr_we = (r_state == S_CLEAR);
    end

    // Clearing owns the CPU port: one byte per clk, low then high of each entry
    assign w_wa    = w_clr_we ? r_clr_cnt[8:1] : addr[8:1];
    assign w_wd    = w_clr_we ? 8'd0 : cpu_dout;
    assign w_we_lo = w_clr_we ? ~r_clr_cnt[0] : (w_cpu_we & ~addr[0]);
    assign w_we_hi = w_clr_we ?  r_clr_cnt[0] : (w_cpu_we &  addr[0]);
`else
    assign busy    = 1'b0;
    assign w_wa    = addr[8:1];
    assign w_wd    = cpu_dout;
    assign w_we_lo = w_cpu_we & ~addr[0];
    assign w_we_hi = w_cpu_we &  addr[0];
`endif

    // CPU port: write plus read-first readback
    always_ff @(posedge clk) begin
        if (w_we_lo) r_pal_lo[w_wa] <= w_wd;
        if (w_we_hi) r_pal_hi[w_wa] <= w_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_dout <= 8'd0;
        else if (busy) r_dout <= 8'd0;
        else           r_dout <= addr[0] ? r_pal_hi[addr[8:1]] : r_pal_lo[addr[8:1]];
    end
    assign dout = r_dout;

    // Video port forwards a same-edge CPU write so the next latch shows it.
    // pxl_cen must be at least two clk apart for this read to settle.
    always_ff @(posedge clk) begin
        r_vid_lo <= (w_we_lo && w_wa == r_idx) ? w_wd      : r_pal_lo[r_idx];
        r_vid_hi <= (w_we_hi && w_wa == r_idx) ? w_wd[6:0] : r_pal_hi[r_idx][6:0];
    end
    assign w_pal = {r_vid_hi, r_vid_lo};

    assign w_a_opq = (|pxl_a[3:0]) & gfx_en[0];
    assign w_b_opq = (|pxl_b[3:0]) & gfx_en[1];

    generate
        if (PRIO_A != 0) begin : g_prio_a
            assign w_idx = w_a_opq ? {1'b0, pxl_a} : w_b_opq ? {1'b1, pxl_b} : 8'd0;
        end else begin : g_prio_b
            assign w_idx = w_b_opq ? {1'b1, pxl_b} : w_a_opq ? {1'b0, pxl_a} : 8'd0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 8'd0;
            r_hbl <= '0;
            r_vbl <= '0;
        end else if (pxl_cen) begin
            r_idx <= w_idx;
            r_hbl <= {r_hbl[BLANK_DLY-2:0], LHBL};
            r_vbl <= {r_vbl[BLANK_DLY-2:0], LVBL};
        end
    end

    // Deeper blanking delays add matching colour stages ahead of the output
    generate
        if (BLANK_DLY > 2) begin : g_col_dly
            logic [14:0] r_col [BLANK_DLY-2];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < BLANK_DLY-2; k++) r_col[k] <= 15'd0;
                end else if (pxl_cen) begin
                    r_col[0] <= w_pal;
                    for (int k = 1; k < BLANK_DLY-2; k++) r_col[k] <= r_col[k-1];
                end
            end
            assign w_col = r_col[BLANK_DLY-3];
        end else begin : g_col_direct
            assign w_col = w_pal;
        end
    endgenerate

    assign w_show = r_hbl[BLANK_DLY-2] & r_vbl[BLANK_DLY-2] & ~busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_rgb <= 15'd0;
        else if (pxl_cen) r_rgb <= w_show ? w_col : 15'd0;
    end

    assign red      = r_rgb[4:0];
    assign green    = r_rgb[9:5];
    assign blue     = r_rgb[14:10];
    assign LHBL_dly = r_hbl[BLANK_DLY-1];
    assign LVBL_dly = r_vbl[BLANK_DLY-1];

endmodule

`default_nettype wire

// File: tb/tb_jtcontra_colmix.sv
// ============================================================================
// Module      : tb_jtcontra_colmix
// Description : Directed-vector bench for jtcontra_colmix.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_jtcontra_colmix;

    logic       clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0;
    logic       LHBL = 1'b1, LVBL = 1'b1;
    logic [6:0] pxl_a = 7'd0, pxl_b = 7'd0;
    logic [1:0] gfx_en = 2'd3;
    logic       cpu_cen = 1'b1, cs = 1'b0, cpu_rnw = 1'b1;
    logic [8:0] addr = 9'd0;
    logic [7:0] cpu_dout = 8'd0;
    logic [7:0] dout;
    logic       busy, LHBL_dly, LVBL_dly;
    logic [4:0] red, green, blue;

    int n_vec = 0;
    int n_bad = 0;

    jtcontra_colmix dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .pxl_a(pxl_a), .pxl_b(pxl_b), .gfx_en(gfx_en), .cpu_cen(cpu_cen),
        .cs(cs), .cpu_rnw(cpu_rnw), .addr(addr), .cpu_dout(cpu_dout),
        .dout(dout), .busy(busy), .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    // One pixel enable every four clocks
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            pxl_cen = 1'b1;
            @(negedge clk);
            pxl_cen = 1'b0;
        end
    end

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; cpu_rnw = 1'b0; addr = a; cpu_dout = d;
        @(negedge clk);
        cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic wait_cen(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!pxl_cen) @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset;
        logic exp_busy;
`ifdef JTCONTRA_PAL_CLEAR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        #23;
        n_vec++; if ({red, green, blue} !== 15'd0) begin n_bad++; $display("FAIL reset_rgb got %h want 0", {red, green, blue}); end
        n_vec++; if (dout !== 8'd0) begin n_bad++; $display("FAIL reset_dout got %h want 0", dout); end
        n_vec++; if (LHBL_dly !== 1'b0) begin n_bad++; $display("FAIL reset_lhbl got %b want 0", LHBL_dly); end
        n_vec++; if (LVBL_dly !== 1'b0) begin n_bad++; $display("FAIL reset_lvbl got %b want 0", LVBL_dly); end
        n_vec++; if (busy !== exp_busy) begin n_bad++; $display("FAIL reset_busy got %b want %b", busy, exp_busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 600 && busy !== 1'b0; i++) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ready_busy got %b want 0", busy); end
    endtask

    task automatic test_priority;
        cpu_wr(9'h00A, 8'h1F); cpu_wr(9'h00B, 8'h7C);   // entry 0x05 = 0x7C1F
        cpu_wr(9'h10A, 8'hE0); cpu_wr(9'h10B, 8'h03);   // entry 0x85 = 0x03E0
        pxl_a = 7'h05; pxl_b = 7'h05; gfx_en = 2'd3;
        wait_cen(3);
        n_vec++; if ({red, green, blue} !== {5'd31, 5'd0, 5'd31}) begin n_bad++; $display("FAIL prio_a_front got %h want %h", {red, green, blue}, {5'd31, 5'd0, 5'd31}); end
        gfx_en = 2'd2;
        wait_cen(1);
        n_vec++; if ({red, green, blue} !== {5'd31, 5'd0, 5'd31}) begin n_bad++; $display("FAIL prio_lat1 got %h want %h", {red, green, blue}, {5'd31, 5'd0, 5'd31}); end
        wait_cen(1);
        n_vec++; if ({red, green, blue} !== {5'd0, 5'd31, 5'd0}) begin n_bad++; $display("FAIL prio_lat2 got %h want %h", {red, green, blue}, {5'd0, 5'd31, 5'd0}); end
        pxl_a = 7'h10; pxl_b = 7'h05; gfx_en = 2'd3;
        wait_cen(3);
        n_vec++; if ({red, green, blue} !== {5'd0, 5'd31, 5'd0}) begin n_bad++; $display("FAIL prio_b_behind got %h want %h", {red, green, blue}, {5'd0, 5'd31, 5'd0}); end
        pxl_a = 7'h05; pxl_b = 7'h20;
        wait_cen(3);
        n_vec++; if ({red, green, blue} !== {5'd31, 5'd0, 5'd31}) begin n_bad++; $display("FAIL prio_a_only got %h want %h", {red, green, blue}, {5'd31, 5'd0, 5'd31}); end
    endtask

    task automatic test_transparency;
        cpu_wr(9'h000, 8'h1F); cpu_wr(9'h001, 8'h00);   // entry 0x00 = 0x001F
        cpu_wr(9'h1F4, 8'h55); cpu_wr(9'h1F5, 8'h55);   // entry 0xFA = 0x5555
        pxl_a = 7'h10; pxl_b = 7'h20; gfx_en = 2'd3;
        wait_cen(3);
        n_vec++; if ({red, green, blue} !== {5'd31, 5'd0, 5'd0}) begin n_bad++; $display("FAIL backdrop got %h want %h", {red, green, blue}, {5'd31, 5'd0, 5'd0}); end
        pxl_b = 7'h7A;
        wait_cen(3);
        n_vec++; if ({red, green, blue} !== {5'd21, 5'd10, 5'd21}) begin n_bad++; $display("FAIL bank_b got %h want %h", {red, green, blue}, {5'd21, 5'd10, 5'd21}); end
        gfx_en = 2'd1;
        wait_cen(3);
        n_vec++; if ({red, green, blue} !== {5'd31, 5'd0, 5'd0}) begin n_bad++; $display("FAIL b_disabled got %h want %h", {red, green, blue}, {5'd31, 5'd0, 5'd0}); end
    endtask

    task automatic test_blanking;
        logic        exp_dly;
        logic [14:0] exp_rgb;
        pxl_a = 7'h05; pxl_b = 7'h05; gfx_en = 2'd3;
        wait_cen(3);
        LHBL = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            wait_cen(1);
            exp_dly = !(i >= 2 && i <= 5);
            exp_rgb = exp_dly ? {5'd31, 5'd0, 5'd31} : 15'd0;
            n_vec++; if (LHBL_dly !== exp_dly) begin n_bad++; $display("FAIL blank_dly[%0d] got %b want %b", i, LHBL_dly, exp_dly); end
            n_vec++; if ({red, green, blue} !== exp_rgb) begin n_bad++; $display("FAIL blank_rgb[%0d] got %h want %h", i, {red, green, blue}, exp_rgb); end
            if (i == 4) LHBL = 1'b1;
        end
    endtask

    task automatic test_cpu_readback;
        cpu_wr(9'h1FF, 8'hAB);
        @(posedge clk); #1;
        n_vec++; if (dout !== 8'hAB) begin n_bad++; $display("FAIL readback got %h want ab", dout); end
        @(negedge clk);
        cs = 1'b1; cpu_rnw = 1'b0; addr = 9'h1FF; cpu_dout = 8'hCD;
        @(posedge clk); #1;
        n_vec++; if (dout !== 8'hAB) begin n_bad++; $display("FAIL read_first got %h want ab", dout); end
        @(negedge clk);
        cs = 1'b0; cpu_rnw = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (dout !== 8'hCD) begin n_bad++; $display("FAIL read_new got %h want cd", dout); end
        @(negedge clk);
        addr = 9'h10A;
        @(posedge clk); #1;
        n_vec++; if (dout !== 8'hE0) begin n_bad++; $display("FAIL read_lo got %h want e0", dout); end
    endtask

    task automatic test_mid_update;
        pxl_a = 7'h05; gfx_en = 2'd3;
        wait_cen(3);
        cpu_wr(9'h00A, 8'h21); cpu_wr(9'h00B, 8'h04);   // entry 0x05 = 0x0421
        n_vec++; if ({red, green, blue} !== {5'd31, 5'd0, 5'd31}) begin n_bad++; $display("FAIL upd_hold got %h want %h", {red, green, blue}, {5'd31, 5'd0, 5'd31}); end
        wait_cen(1);
        n_vec++; if ({red, green, blue} !== {5'd1, 5'd1, 5'd1}) begin n_bad++; $display("FAIL upd_new got %h want %h", {red, green, blue}, {5'd1, 5'd1, 5'd1}); end
        // High byte written on the clk just before the next pixel enable
        wait_cen(1);
        @(negedge clk); @(negedge clk);
        cpu_wr(9'h00B, 8'h7C);
        wait_cen(1);
        n_vec++; if ({red, green, blue} !== {5'd1, 5'd1, 5'd31}) begin n_bad++; $display("FAIL upd_late got %h want %h", {red, green, blue}, {5'd1, 5'd1, 5'd31}); end
    endtask

    task automatic test_reset_mid;
        wait_cen(2);
        n_vec++; if ({red, green, blue} !== {5'd1, 5'd1, 5'd31}) begin n_bad++; $display("FAIL pre_rst got %h want %h", {red, green, blue}, {5'd1, 5'd1, 5'd31}); end
        #3 rst = 1'b1;
        #1;
        n_vec++; if ({red, green, blue} !== 15'd0) begin n_bad++; $display("FAIL async_rst_rgb got %h want 0", {red, green, blue}); end
        n_vec++; if (LHBL_dly !== 1'b0) begin n_bad++; $display("FAIL async_rst_lhbl got %b want 0", LHBL_dly); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 600 && busy !== 1'b0; i++) @(negedge clk);
    endtask

`ifdef JTCONTRA_PAL_CLEAR_EN
    task automatic test_clear;
        int          n_busy;
        logic [8:0]  chk_addr [5];
        chk_addr = '{9'h000, 9'h00A, 9'h00B, 9'h10B, 9'h1FF};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_busy = 0;
        repeat (300) begin @(posedge clk); #1; if (busy) n_busy++; end
        n_vec++; if ({red, green, blue} !== 15'd0) begin n_bad++; $display("FAIL clr_rgb got %h want 0", {red, green, blue}); end
        cpu_wr(9'h000, 8'h55);
        n_busy += 2;
        for (int i = 0; i < 400 && busy === 1'b1; i++) begin @(posedge clk); #1; if (busy) n_busy++; end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_timeout busy %b want 0", busy); end
        n_vec++; if (n_busy < 512 || n_busy > 513) begin n_bad++; $display("FAIL clr_len got %0d want 512..513", n_busy); end
        cs = 1'b1; cpu_rnw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); addr = chk_addr[i];
            @(posedge clk); #1;
            n_vec++; if (dout !== 8'h00) begin n_bad++; $display("FAIL clr_read[%h] got %h want 0", chk_addr[i], dout); end
        end
        cs = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_priority;
        test_transparency;
        test_blanking;
        test_cpu_readback;
        test_mid_update;
        test_reset_mid;
`ifdef JTCONTRA_PAL_CLEAR_EN
        test_clear;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
